// File: rtl/encoder_scan_pkg.sv
// Shared definitions for the scanning encoder family: FSM state encoding and
// the default output-code width.
package encoder_scan_pkg;

  localparam int DEFAULT_N_OUT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/encoder_scan_if.sv
// Input-word and result handshakes of the scanning encoder.
// The master side drives words in and accepts results; the slave side is the encoder.
interface encoder_scan_if #(
  parameter int N_OUT = encoder_scan_pkg::DEFAULT_N_OUT,
  parameter int WIDTH = 2 ** N_OUT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_code;
  logic             out_found;
  logic             out_multi;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_found, out_multi
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_found, out_multi
  );

endinterface

// File: rtl/encoder_scan_ctrl.sv
// Sequencer for the scanning encoder: handshakes, MSB-first bit index and
// end-of-scan strobe.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | in_ready high, waiting for a word
//   ST_SCAN | one captured bit examined per cycle, idx WIDTH-1 down to 0
//   ST_DONE | out_valid high, result held until out_ready
module encoder_scan_ctrl
  import encoder_scan_pkg::*;
#(
  parameter int N_OUT = DEFAULT_N_OUT,
  parameter int WIDTH = 2 ** N_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             accept,
  output logic             scan_en,
  output logic [N_OUT-1:0] bit_idx,
  output logic             done
);

  state_t           state_q;
  state_t           state_nxt;
  logic [N_OUT-1:0] idx_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Handshake strobes decoded from the registered state.
  assign accept  = (state_q == ST_IDLE) && in_valid;
  assign scan_en = (state_q == ST_SCAN);
  assign done    = (state_q == ST_SCAN) && (idx_q == '0);
  assign bit_idx = idx_q;

  // Next-state logic; idx==0 ends the scan so the counter never wraps.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)        state_nxt = ST_SCAN;
      ST_SCAN: if (idx_q == '0)     state_nxt = ST_DONE;
      ST_DONE: if (out_ready)       state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // State, scan counter and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      in_ready_q  <= (state_nxt == ST_IDLE);
      out_valid_q <= (state_nxt == ST_DONE);
      if (accept) begin
        idx_q <= N_OUT'(WIDTH - 1);
      end else if (scan_en && (idx_q != '0)) begin
        idx_q <= idx_q - N_OUT'(1);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/encoder_scan.sv
// Sequential priority encoder: captures a word, scans it MSB first and reports
// the highest set index with found/multi-hot flags.
module encoder_scan
  import encoder_scan_pkg::*;
#(
  parameter int N_OUT = DEFAULT_N_OUT,
  parameter int WIDTH = 2 ** N_OUT
) (
  input logic          clk,
  input logic          rst,
  encoder_scan_if.slave bus
);

  logic             accept;
  logic             scan_en;
  logic             done;
  logic [N_OUT-1:0] bit_idx;

  logic [WIDTH-1:0] cap_q;
  logic [N_OUT-1:0] code_q, code_nxt;
  logic             found_q, found_nxt;
  logic             multi_q, multi_nxt;
  logic [N_OUT-1:0] out_code_q;
  logic             out_found_q;
  logic             out_multi_q;

  encoder_scan_ctrl #(
    .N_OUT (N_OUT),
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .accept    (accept),
    .scan_en   (scan_en),
    .bit_idx   (bit_idx),
    .done      (done)
  );

  // The first set bit met while scanning downward is the highest; later ones flag multi-hot.
  always_comb begin
    code_nxt  = code_q;
    found_nxt = found_q;
    multi_nxt = multi_q;
    if (scan_en && cap_q[bit_idx]) begin
      if (!found_q) begin
        code_nxt  = bit_idx;
        found_nxt = 1'b1;
      end else begin
        multi_nxt = 1'b1;
      end
    end
  end

  // Capture and running result; the visible outputs load only at end of scan,
  // so they hold the previous result until the next DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q       <= '0;
      code_q      <= '0;
      found_q     <= 1'b0;
      multi_q     <= 1'b0;
      out_code_q  <= '0;
      out_found_q <= 1'b0;
      out_multi_q <= 1'b0;
    end else begin
      if (accept) begin
        cap_q   <= bus.in_data;
        code_q  <= '0;
        found_q <= 1'b0;
        multi_q <= 1'b0;
      end else begin
        code_q  <= code_nxt;
        found_q <= found_nxt;
        multi_q <= multi_nxt;
      end
      if (done) begin
        out_code_q  <= code_nxt;
        out_found_q <= found_nxt;
        out_multi_q <= multi_nxt;
      end
    end
  end

  assign bus.out_code  = out_code_q;
  assign bus.out_found = out_found_q;
  assign bus.out_multi = out_multi_q;

endmodule

// File: tb/tb_encoder_scan.sv
// Directed + random bench for encoder_scan against a popcount/highest-bit model.
module tb_encoder_scan;
  import encoder_scan_pkg::*;

  localparam int N_OUT = DEFAULT_N_OUT;
  localparam int WIDTH = 2 ** N_OUT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  encoder_scan_if #(.N_OUT(N_OUT), .WIDTH(WIDTH)) bus ();

  encoder_scan #(.N_OUT(N_OUT), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: highest set index, any-set, more-than-one-set.
  function automatic void ref_encode(input logic [WIDTH-1:0] w, output logic [N_OUT-1:0] c,
                                     output logic f, output logic m);
    f = (w != '0);
    m = ($countones(w) > 1);
    c = '0;
    for (int i = 0; i < WIDTH; i++) if (w[i]) c = N_OUT'(i);
  endfunction

  // Called at a negedge; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] w);
    logic ok;
    ok = 1'b0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Called just after the accepting edge; measures latency, checks result,
  // optional backpressure, then completes the result handshake.
  task automatic collect(input logic [WIDTH-1:0] w, input int bp);
    logic [N_OUT-1:0] c;
    logic             f, m, got, ready_seen, stable;
    int               lat;
    ref_encode(w, c, f, m);
    bus.out_ready = (bp == 0);
    lat        = 1;
    got        = 1'b0;
    ready_seen = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
      else begin
        if (bus.in_ready) ready_seen = 1'b1;
        @(posedge clk);
        lat++;
      end
    end
    if (!got) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    check("latency", 32'(lat), 32'(WIDTH + 1));
    check("in_ready_busy", 32'(ready_seen), 32'd0);
    check("code", 32'(bus.out_code), 32'(c));
    check("found", 32'(bus.out_found), 32'(f));
    check("multi", 32'(bus.out_multi), 32'(m));
    if (bp > 0) begin
      stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (!(bus.out_valid && !bus.in_ready && bus.out_code == c &&
              bus.out_found == f && bus.out_multi == m)) stable = 1'b0;
      end
      check("bp_stable", 32'(stable), 32'd1);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_hs_code_held", 32'(bus.out_code), 32'(c));
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    logic             quiet;
    if (WIDTH != 2 ** N_OUT) begin
      $display("FAIL param WIDTH=%0d N_OUT=%0d", WIDTH, N_OUT);
      $fatal(1, "bad parameters");
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_code", 32'(bus.out_code), 32'd0);
    check("rst_found", 32'(bus.out_found), 32'd0);
    check("rst_multi", 32'(bus.out_multi), 32'd0);

    // Directed words from the plan.
    send(4'b0100); collect(4'b0100, 0);
    send(4'b0000); collect(4'b0000, 0);
    send(4'b1010); collect(4'b1010, 0);
    send(4'b0001); collect(4'b0001, 0);

    // Backpressure for 10 cycles.
    send(4'b0110); collect(4'b0110, 10);

    // Word offered during SCAN is ignored, then taken once IDLE returns.
    send(4'b0010);
    bus.in_data  = 4'b1000;
    bus.in_valid = 1'b1;
    collect(4'b0010, 0);
    send(4'b1000); collect(4'b1000, 0);

    // Reset in the second SCAN cycle discards the word.
    send(4'b1111);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midscan_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midscan_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midscan_rst_found", 32'(bus.out_found), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) quiet = 1'b1 & 1'b0;
    end
    check("midscan_rst_quiet", 32'(quiet), 32'd1);

    // Random words, some with short backpressure.
    for (int i = 0; i < 12; i++) begin
      w = WIDTH'($urandom);
      send(w);
      collect(w, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
